timing_adjust: RTL and testbench

- Parametrised successor to the three-field H/M/S校时 block.
- Holds hour, minute and second BCD registers in a single clock domain (no gated clocks).
- Adjusts one selected field with press-step plus hold-to-auto-repeat, supports synchronous bulk load, and presents hours in 24h or 12h format.
- Sits between the front-panel button logic and the timer/alarm register banks.

---
 rtl/timing_adjust.sv | 238 +++++++++++++++++++++++
 tb/tb_timing_adjust.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/timing_adjust.sv
// timing_adjust: hour/minute/second BCD setting block.
// One field at a time is adjusted from the front-panel buttons. A press steps
// the field once. Holding the press starts auto-repeat, paced by the 1 Hz TICK.
// A synchronous bulk load overrides button activity. Hours are stored in 24h
// form, and the 12h view is derived combinationally on the outputs.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | no request active; the next valid request steps and enters HOLD
// HOLD   | request held; counting TICKs until auto-repeat begins
// REPEAT | request still held; selected field steps once per TICK
// LOCK   | after reset or load; waits for request release before accepting
module timing_adjust #(
    parameter logic [7:0]  S_MAX      = 8'h59,
    parameter logic [7:0]  M_MAX      = 8'h59,
    parameter logic [7:0]  H_MAX      = 8'h23,
    parameter int unsigned HOLD_TICKS = 3
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       TICK,
    input  logic [1:0] SEL,
    input  logic       UP,
    input  logic       DOWN,
    input  logic       MODE_12H,
    input  logic       LOAD,
    input  logic [7:0] D_H,
    input  logic [7:0] D_M,
    input  logic [7:0] D_S,
    output logic [7:0] Q_H,
    output logic [7:0] Q_M,
    output logic [7:0] Q_S,
    output logic       PM,
    output logic       ADJ,
    output logic       CHG
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;

    localparam logic [3:0] HOLD_LIM = HOLD_TICKS[3:0];

    localparam logic [1:0] SEL_SEC  = 2'b00;
    localparam logic [1:0] SEL_MIN  = 2'b01;
    localparam logic [1:0] SEL_HOUR = 2'b10;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic       dir_q, dir_d;
    logic [7:0] h_q, h_d;
    logic [7:0] m_q, m_d;
    logic [7:0] s_q, s_d;
    logic       chg_q, chg_d;

    logic       req;
    logic       new_press;
    logic       do_step;

    logic [7:0] h_bin;
    logic [7:0] h_disp;

    // Packed-BCD increment with wrap from max back to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v >= max)
            r = 8'h00;
        else if (v[3:0] >= 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Packed-BCD decrement with wrap from 00 to max.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == 8'h00)
            r = max;
        else if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    // A bad load value clears only its own field, so the other fields stay usable.
    function automatic logic [7:0] load_fix(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v > max))
            r = 8'h00;
        else
            r = v;
        return r;
    endfunction

    function automatic logic [7:0] bcd_to_bin(input logic [7:0] v);
        logic [7:0] tens;
        tens = {4'd0, v[7:4]};
        return (tens << 3) + (tens << 1) + {4'd0, v[3:0]};
    endfunction

    // Only handles 0..19, which covers the 12h display range.
    function automatic logic [7:0] bin_to_bcd(input logic [7:0] v);
        logic [7:0] tmp;
        logic [7:0] r;
        if (v >= 8'd10) begin
            tmp = v - 8'd10;
            r   = {4'd1, tmp[3:0]};
        end else begin
            r = {4'd0, v[3:0]};
        end
        return r;
    endfunction

    // State, hold counter, latched press identity, field registers and change pulse.
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state_q <= ST_LOCK;
            cnt_q   <= 4'd0;
            sel_q   <= 2'b11;
            dir_q   <= 1'b0;
            h_q     <= 8'h00;
            m_q     <= 8'h00;
            s_q     <= 8'h00;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            h_q     <= h_d;
            m_q     <= m_d;
            s_q     <= s_d;
            chg_q   <= chg_d;
        end
    end

    // Next-state logic: request decode, press/hold/repeat sequencing, load override.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        dir_d     = dir_q;
        do_step   = 1'b0;
        req       = (UP ^ DOWN) && (SEL != 2'b11);
        new_press = (SEL != sel_q) || (UP != dir_q);

        if (LOAD) begin
            state_d = ST_LOCK;
        end else begin
            case (state_q)
                ST_LOCK: begin
                    if (!req)
                        state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (req) begin
                        do_step = 1'b1;
                        cnt_d   = 4'd0;
                        sel_d   = SEL;
                        dir_d   = UP;
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (!req) begin
                        state_d = ST_IDLE;
                    end else if (new_press) begin
                        // A new press takes precedence; a TICK on this edge is not counted.
                        do_step = 1'b1;
                        cnt_d   = 4'd0;
                        sel_d   = SEL;
                        dir_d   = UP;
                        state_d = ST_HOLD;
                    end else if (TICK) begin
                        if (state_q == ST_HOLD) begin
                            cnt_d = cnt_q + 4'd1;
                            if ((cnt_q + 4'd1) >= HOLD_LIM)
                                state_d = ST_REPEAT;
                        end else begin
                            do_step = 1'b1;
                        end
                    end
                end
                default: state_d = ST_LOCK;
            endcase
        end
    end

    // Field update: a load writes all three fields; a step writes only the selected field.
    always_comb begin
        h_d   = h_q;
        m_d   = m_q;
        s_d   = s_q;
        chg_d = 1'b0;
        if (LOAD) begin
            h_d   = load_fix(D_H, H_MAX);
            m_d   = load_fix(D_M, M_MAX);
            s_d   = load_fix(D_S, S_MAX);
            chg_d = 1'b1;
        end else if (do_step) begin
            chg_d = 1'b1;
            case (SEL)
                SEL_SEC:  s_d = UP ? bcd_inc(s_q, S_MAX) : bcd_dec(s_q, S_MAX);
                SEL_MIN:  m_d = UP ? bcd_inc(m_q, M_MAX) : bcd_dec(m_q, M_MAX);
                SEL_HOUR: h_d = UP ? bcd_inc(h_q, H_MAX) : bcd_dec(h_q, H_MAX);
                default:  chg_d = 1'b0;
            endcase
        end
    end

    // Hour presentation: 12h view derived from the 24h register, state untouched.
    always_comb begin
        h_bin  = bcd_to_bin(h_q);
        h_disp = h_bin;
        Q_H    = h_q;
        PM     = 1'b0;
        if (MODE_12H) begin
            PM = (h_bin >= 8'd12);
            if (h_bin == 8'd0)
                h_disp = 8'd12;
            else if (h_bin > 8'd12)
                h_disp = h_bin - 8'd12;
            Q_H = bin_to_bcd(h_disp);
        end
    end

    assign Q_M = m_q;
    assign Q_S = s_q;
    assign ADJ = (state_q == ST_HOLD) || (state_q == ST_REPEAT);
    assign CHG = chg_q;

endmodule

// File: tb/tb_timing_adjust.sv
// Directed self-checking bench for timing_adjust (default parameters, HOLD_TICKS=3).
module tb_timing_adjust;

    logic       CP = 1'b0;
    logic       CR = 1'b1;
    logic       TICK = 1'b0;
    logic [1:0] SEL = 2'b11;
    logic       UP = 1'b0;
    logic       DOWN = 1'b0;
    logic       MODE_12H = 1'b0;
    logic       LOAD = 1'b0;
    logic [7:0] D_H = 8'h00;
    logic [7:0] D_M = 8'h00;
    logic [7:0] D_S = 8'h00;
    logic [7:0] Q_H, Q_M, Q_S;
    logic       PM, ADJ, CHG;

    int n_checks = 0;
    int n_errors = 0;

    timing_adjust dut (
        .CP(CP), .CR(CR), .TICK(TICK), .SEL(SEL), .UP(UP), .DOWN(DOWN),
        .MODE_12H(MODE_12H), .LOAD(LOAD), .D_H(D_H), .D_M(D_M), .D_S(D_S),
        .Q_H(Q_H), .Q_M(Q_M), .Q_S(Q_S), .PM(PM), .ADJ(ADJ), .CHG(CHG)
    );

    always #5 CP = ~CP;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge CP);
        #1;
    endtask

    task automatic tick_pulse();
        TICK = 1'b1;
        cyc();
        TICK = 1'b0;
        cyc();
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        D_H = h; D_M = m; D_S = s;
        LOAD = 1'b1;
        cyc();
        LOAD = 1'b0;
    endtask

    initial begin
        // Reset values in both hour views
        MODE_12H = 1'b1;
        repeat (2) cyc();
        check("rst_qh_12h", Q_H, 8'h12);
        check("rst_pm", {7'd0, PM}, 8'd0);
        MODE_12H = 1'b0;
        #1;
        check("rst_qh", Q_H, 8'h00);
        check("rst_qm", Q_M, 8'h00);
        check("rst_qs", Q_S, 8'h00);
        check("rst_chg", {7'd0, CHG}, 8'd0);
        check("rst_adj", {7'd0, ADJ}, 8'd0);
        CR = 1'b0;
        cyc();

        // Single press on seconds
        SEL = 2'b00; UP = 1'b1;
        #1;
        check("press_pre_qs", Q_S, 8'h00);
        cyc();
        check("press_qs", Q_S, 8'h01);
        check("press_chg", {7'd0, CHG}, 8'd1);
        check("press_adj", {7'd0, ADJ}, 8'd1);
        UP = 1'b0;
        cyc();
        check("release_qs", Q_S, 8'h01);
        check("release_chg", {7'd0, CHG}, 8'd0);
        check("release_adj", {7'd0, ADJ}, 8'd0);

        // Minute wrap up, hour wrap down
        do_load(8'h00, 8'h59, 8'h00);
        check("load_chg", {7'd0, CHG}, 8'd1);
        check("load_qm", Q_M, 8'h59);
        cyc();
        SEL = 2'b01; UP = 1'b1;
        cyc();
        check("min_wrap_qm", Q_M, 8'h00);
        check("min_wrap_qh", Q_H, 8'h00);
        UP = 1'b0;
        cyc();
        SEL = 2'b10; DOWN = 1'b1;
        cyc();
        check("hour_dec_wrap", Q_H, 8'h23);
        DOWN = 1'b0;
        cyc();

        // Hold and auto-repeat: press step, 3 hold ticks, then a step per tick
        do_load(8'h00, 8'h00, 8'h00);
        cyc();
        SEL = 2'b00; UP = 1'b1;
        cyc();
        check("rep_press_qs", Q_S, 8'h01);
        for (int k = 1; k <= 8; k++) begin
            TICK = 1'b1;
            cyc();
            TICK = 1'b0;
            check($sformatf("rep_chg_t%0d", k), {7'd0, CHG}, (k >= 4) ? 8'd1 : 8'd0);
            cyc();
            check($sformatf("rep_qs_t%0d", k), Q_S, (k >= 4) ? 8'(k - 2) : 8'h01);
            check($sformatf("rep_adj_t%0d", k), {7'd0, ADJ}, 8'd1);
        end
        check("rep_final_qs", Q_S, 8'h06);

        // Load while UP held: invalid fields clear, then lock out until release
        do_load(8'h25, 8'h3A, 8'h45);
        check("ld_qh", Q_H, 8'h00);
        check("ld_qm", Q_M, 8'h00);
        check("ld_qs", Q_S, 8'h45);
        check("ld_adj", {7'd0, ADJ}, 8'd0);
        repeat (3) tick_pulse();
        check("ld_lock_qs", Q_S, 8'h45);
        check("ld_lock_adj", {7'd0, ADJ}, 8'd0);
        UP = 1'b0;
        cyc();
        UP = 1'b1;
        cyc();
        check("ld_repress_qs", Q_S, 8'h46);
        UP = 1'b0;
        cyc();

        // 12h presentation
        MODE_12H = 1'b1;
        do_load(8'h00, 8'h00, 8'h00);
        check("h12_00_qh", Q_H, 8'h12);
        check("h12_00_pm", {7'd0, PM}, 8'd0);
        do_load(8'h11, 8'h00, 8'h00);
        check("h12_11_qh", Q_H, 8'h11);
        check("h12_11_pm", {7'd0, PM}, 8'd0);
        do_load(8'h12, 8'h00, 8'h00);
        check("h12_12_qh", Q_H, 8'h12);
        check("h12_12_pm", {7'd0, PM}, 8'd1);
        do_load(8'h19, 8'h00, 8'h00);
        check("h12_19_qh", Q_H, 8'h07);
        do_load(8'h23, 8'h00, 8'h00);
        check("h12_23_qh", Q_H, 8'h11);
        check("h12_23_pm", {7'd0, PM}, 8'd1);
        cyc();
        SEL = 2'b10; UP = 1'b1;
        cyc();
        check("h12_step_qh", Q_H, 8'h12);
        check("h12_step_pm", {7'd0, PM}, 8'd0);
        UP = 1'b0;
        MODE_12H = 1'b0;
        cyc();
        check("h24_back_qh", Q_H, 8'h00);
        check("h24_back_pm", {7'd0, PM}, 8'd0);

        // No-request patterns: both buttons, and SEL=11
        do_load(8'h05, 8'h30, 8'h20);
        cyc();
        SEL = 2'b00; UP = 1'b1; DOWN = 1'b1;
        for (int k = 0; k < 5; k++) begin
            TICK = 1'b1;
            cyc();
            TICK = 1'b0;
            check("both_chg", {7'd0, CHG}, 8'd0);
            cyc();
        end
        check("both_qs", Q_S, 8'h20);
        DOWN = 1'b0; SEL = 2'b11;
        for (int k = 0; k < 5; k++) begin
            TICK = 1'b1;
            cyc();
            TICK = 1'b0;
            check("none_chg", {7'd0, CHG}, 8'd0);
            cyc();
        end
        check("none_qh", Q_H, 8'h05);
        check("none_qm", Q_M, 8'h30);
        check("none_qs", Q_S, 8'h20);
        UP = 1'b0;
        cyc();

        // Units borrow on decrement, then re-press on field and direction change
        SEL = 2'b00; DOWN = 1'b1;
        cyc();
        check("dec_borrow_qs", Q_S, 8'h19);
        SEL = 2'b01;
        cyc();
        check("sel_change_qm", Q_M, 8'h29);
        check("sel_change_adj", {7'd0, ADJ}, 8'd1);
        DOWN = 1'b0; UP = 1'b1;
        cyc();
        check("dir_change_qm", Q_M, 8'h30);
        UP = 1'b0;
        cyc();

        // Reset during REPEAT with UP held
        SEL = 2'b00; UP = 1'b1;
        cyc();
        repeat (4) tick_pulse();
        check("pre_rst_qs", Q_S, 8'h21);
        check("pre_rst_adj", {7'd0, ADJ}, 8'd1);
        CR = 1'b1;
        #1;
        check("mid_rst_qs", Q_S, 8'h00);
        check("mid_rst_qm", Q_M, 8'h00);
        check("mid_rst_qh", Q_H, 8'h00);
        check("mid_rst_adj", {7'd0, ADJ}, 8'd0);
        cyc();
        CR = 1'b0;
        cyc();
        repeat (3) tick_pulse();
        check("post_rst_qs", Q_S, 8'h00);
        check("post_rst_adj", {7'd0, ADJ}, 8'd0);
        UP = 1'b0;
        cyc();
        UP = 1'b1;
        cyc();
        check("post_rst_press", Q_S, 8'h01);
        UP = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
